muldiv_seq: RTL and testbench

//  Iterative multiply/divide unit beside the ALU in the execute stage. Operands come from the

---
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_muldiv_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
//   start, ALUControl, a, b       : request (driven by master)
//   busy, done, Result, Long,
//   ALUFlags                      : status and result (driven by slave)
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Long;
    logic [3:0]       ALUFlags;

    modport master (
        output start, ALUControl, a, b,
        input  busy, done, Result, Long, ALUFlags
    );

    modport slave (
        input  start, ALUControl, a, b,
        output busy, done, Result, Long, ALUFlags
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one radix-2 step per cycle, WIDTH steps
// per operation. Shift-add multiply on operand magnitudes (sign fixed up at
// the end for SMUL) and restoring unsigned divide.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   io     : muldiv_seq_if.slave (start/ALUControl/a/b in,
//            busy/done/Result/Long/ALUFlags out)
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  io
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // op encoding is ALUControl[1:0]
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_SMUL = 2'b10;

    state_t state, state_nx;

    logic [CW-1:0]    counter;
    logic [1:0]       op;
    logic             neg;     // SMUL: negate final product
    logic [WIDTH-1:0] hi;      // mul: accumulator high half; div: partial remainder
    logic [WIDTH-1:0] lo;      // mul: multiplier shifting out; div: dividend in, quotient out
    logic [WIDTH-1:0] opb;     // mul: multiplicand magnitude; div: divisor

    logic [WIDTH-1:0] result_q, long_q;
    logic [3:0]       flags_q;

    logic accept, last;
    assign accept = (state == S_IDLE || state == S_DONE) && io.start && io.ALUControl[2];
    assign last   = (counter == CW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_RUN;
            S_RUN:   if (last)   state_nx = S_DONE;
            S_DONE:  state_nx = accept ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign io.busy     = (state == S_RUN);
    assign io.done     = (state == S_DONE);
    assign io.Result   = result_q;
    assign io.Long     = long_q;
    assign io.ALUFlags = flags_q;

    // ---------------- operand capture ----------------
    logic             in_smul;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign in_smul = (io.ALUControl[1:0] == OP_SMUL);
    // Most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
    assign mag_a = (in_smul && io.a[WIDTH-1]) ? (~io.a + 1'b1) : io.a;
    assign mag_b = (in_smul && io.b[WIDTH-1]) ? (~io.b + 1'b1) : io.b;

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [WIDTH-1:0]   nh, nl;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opb});
        // When ge, shifted - opb < opb, so the low WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - opb;
        if (op == OP_DIV) begin
            nh = ge ? diff : shifted[WIDTH-1:0];
            nl = {lo[WIDTH-2:0], ge};
        end else begin
            nh = sum[WIDTH:1];
            nl = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // ---------------- final result formatting ----------------
    logic [2*WIDTH-1:0] prod, sprod;
    logic [WIDTH-1:0]   fin_res, fin_long;
    logic [3:0]         fin_flags;

    always_comb begin
        prod      = {nh, nl};
        sprod     = neg ? (~prod + 1'b1) : prod;
        fin_res   = nl;
        fin_long  = '0;
        fin_flags = 4'b0000;
        case (op)
            OP_DIV: begin
                fin_res   = nl;
                fin_long  = nh;
                fin_flags = {nl[WIDTH-1], (nl == '0), 2'b00};
            end
            OP_MUL: begin
                fin_res   = nl;
                fin_long  = '0;
                fin_flags = {nl[WIDTH-1], (nl == '0), 2'b00};
            end
            default: begin
                fin_res   = sprod[WIDTH-1:0];
                fin_long  = sprod[2*WIDTH-1:WIDTH];
                fin_flags = {sprod[2*WIDTH-1], (sprod == '0), 2'b00};
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= '0;
            op       <= '0;
            neg      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            result_q <= '0;
            long_q   <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            counter <= '0;
            op      <= io.ALUControl[1:0];
            hi      <= '0;
            if (io.ALUControl[1:0] == OP_DIV) begin
                lo  <= io.a;
                opb <= io.b;
                neg <= 1'b0;
            end else begin
                lo  <= mag_a;
                opb <= mag_b;
                neg <= in_smul && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            end
        end else if (state == S_RUN) begin
            hi      <= nh;
            lo      <= nl;
            counter <= counter + CW'(1);
            if (last) begin
                result_q <= fin_res;
                long_q   <= fin_long;
                flags_q  <= fin_flags;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops vs a
// plain-arithmetic reference, plus back-to-back, rejected-op and mid-op reset.
module tb_muldiv_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(W)) bus ();
    muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a, b;
        logic [31:0] res, lng;
        logic [3:0]  flg;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic ref_model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] r, output logic [31:0] l, output logic [3:0] f);
        logic [63:0] p;
        longint sp;
        r = 0; l = 0; f = 0;
        case (c)
            3'b101: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0]; l = 0;
                f = {r[31], r == 0, 2'b00};
            end
            3'b111: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0]; l = p[63:32];
                f = {l[31], p == 0, 2'b00};
            end
            3'b110: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                p = sp;
                r = p[31:0]; l = p[63:32];
                f = {l[31], p == 0, 2'b00};
            end
            default: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; l = x; end
                else begin r = x / y; l = x % y; end
                f = {r[31], r == 0, 2'b00};
            end
        endcase
    endtask

    // Issue one op and wait for done; returns latency in cycles counted from
    // the accepting edge, and whether outputs held steady while busy.
    task automatic run_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output bit stable);
        logic [31:0] s_r, s_l;
        logic [3:0]  s_f;
        @(negedge clk);
        bus.start = 1'b1; bus.ALUControl = c; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        // scramble operands: the unit must not re-sample them
        bus.a = $urandom; bus.b = $urandom;
        s_r = bus.Result; s_l = bus.Long; s_f = bus.ALUFlags;
        stable = 1'b1;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (bus.Result !== s_r || bus.Long !== s_l || bus.ALUFlags !== s_f) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[7];

    initial begin
        int lat;
        bit stable;
        logic [31:0] er, el;
        logic [3:0]  ef;

        vecs[0] = '{"umul_max",   3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000};
        vecs[1] = '{"smul_neg2x3",3'b110, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 4'b1000};
        vecs[2] = '{"smul_minsq", 3'b110, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 4'b0000};
        vecs[3] = '{"div_5_by_0", 3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         4'b1000};
        vecs[4] = '{"mul_zero",   3'b101, 32'd0,         32'd123,       32'h0,         32'h0,         4'b0100};
        vecs[5] = '{"mul_6x7",    3'b101, 32'd6,         32'd7,         32'd42,        32'h0,         4'b0000};
        vecs[6] = '{"div_100_7",  3'b100, 32'd100,       32'd7,         32'd14,        32'd2,         4'b0000};

        reset = 1'b1;
        bus.start = 1'b0; bus.ALUControl = 3'b000; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.ALUFlags, bus.Result, bus.Long}, '0);
        reset = 1'b0;

        // ---- directed table ----
        foreach (vecs[i]) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, stable);
            chk({vecs[i].name, "_lat"},    64'(lat), 64'(W + 1));
            chk({vecs[i].name, "_result"}, {32'b0, bus.Result}, {32'b0, vecs[i].res});
            chk({vecs[i].name, "_long"},   {32'b0, bus.Long},   {32'b0, vecs[i].lng});
            chk({vecs[i].name, "_flags"},  {60'b0, bus.ALUFlags}, {60'b0, vecs[i].flg});
            chk({vecs[i].name, "_stable"}, 64'(stable), 64'(1));
        end
        @(negedge clk);
        chk("done_one_cycle", {bus.done, bus.busy}, 2'b00);

        // ---- rejected op: ALUControl[2]==0 ----
        bus.start = 1'b1; bus.ALUControl = 3'b010; bus.a = 32'd9; bus.b = 32'd9;
        begin
            bit seen = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (bus.busy || bus.done) seen = 1'b1;
            end
            chk("reject_op", 64'(seen), 64'(0));
            chk("reject_hold", {32'b0, bus.Result}, {32'b0, 32'd14});
        end
        bus.start = 1'b0;

        // ---- randomized vs reference ----
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  c;
            logic [31:0] x, y;
            c = 3'(4 + $urandom_range(0, 3));
            x = rnd_operand();
            y = rnd_operand();
            ref_model(c, x, y, er, el, ef);
            run_op(c, x, y, lat, stable);
            if (lat != W + 1) chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(W + 1));
            chk($sformatf("rnd%0d_op%b_%h_%h", n, c, x, y),
                {bus.ALUFlags, bus.Long, bus.Result}, {ef, el, er});
        end

        // ---- back-to-back: start held through DONE ----
        @(negedge clk);
        bus.start = 1'b1; bus.ALUControl = 3'b111; bus.a = 32'd1000; bus.b = 32'd1000;
        @(negedge clk);
        bus.ALUControl = 3'b100; bus.a = 32'd1000; bus.b = 32'd33;
        begin
            int k = 1;
            while (!bus.done && k < 100) begin @(negedge clk); k++; end
            chk("b2b_first_lat", 64'(k), 64'(W + 1));
        end
        chk("b2b_first_res", {bus.Long, bus.Result}, 64'd1000000);
        chk("b2b_gap_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_restart", {bus.busy, bus.done}, 2'b10);
        begin
            int k = 1;
            while (!bus.done && k < 100) begin @(negedge clk); k++; end
            chk("b2b_second_spacing", 64'(k), 64'(W + 1));
        end
        chk("b2b_second_res", {bus.Long, bus.Result}, {32'd10, 32'd30});

        // ---- reset during a DIV ----
        @(negedge clk);
        bus.start = 1'b1; bus.ALUControl = 3'b100; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop_reset", {bus.busy, bus.done, bus.ALUFlags, bus.Result, bus.Long}, '0);
        @(negedge clk);
        chk("midop_idle", {bus.busy, bus.done}, 2'b00);
        run_op(3'b101, 32'd6, 32'd7, lat, stable);
        chk("post_reset_lat", 64'(lat), 64'(W + 1));
        chk("post_reset_mul", {bus.Long, bus.Result}, 64'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
